uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter BAUD_CNT_MAX, default 5207, the last value of the per-bit clock count (bit period = BAUD_CNT_MAX+1 clocks); benches SHALL override it to 28.
REQ-002 The block SHALL have port sclk  input  1  the single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port srst  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port rs232_rx  input  1  asynchronous serial line, idle high.
REQ-005 The block SHALL have port rx_data  output  8  last correctly framed byte, LSB received first.
REQ-006 The block SHALL have port po_flag  output  1  one-clock pulse: rx_data updated this cycle.
REQ-007 The block SHALL have port frame_err  output  1  one-clock pulse: stop bit sampled low.
REQ-008 The block SHALL have port parity_err  output  1  one-clock pulse: parity mismatch.
REQ-009 The block SHALL have port rx_busy  output  1  high while a frame is being received (FSM not IDLE).

Function
REQ-010 The block SHALL pass rs232_rx through a 3-flop synchronizer (s1,s2,s3) and SHALL detect a start edge when s2==0 and s3==1.
REQ-011 The block SHALL implement FSM states IDLE, START, DATA, PARITY (only when configured), STOP.
REQ-012 In IDLE, a start edge SHALL move to START and clear baud_cnt (13 bits) to 0; edges in any other state SHALL be ignored.
REQ-013 Outside IDLE, baud_cnt SHALL increment each clock and wrap from BAUD_CNT_MAX to 0; one wrap = one bit period.
REQ-014 The sample point SHALL be the cycle baud_cnt == BAUD_CNT_MAX/2 (integer divide), sampling s3.
REQ-015 START: sample 1 -> false start, return to IDLE with no output pulse; sample 0 -> DATA with bit_cnt=0.
REQ-016 DATA: each sample SHALL shift into a shift register LSB-first; after the sample with bit_cnt==7 go to PARITY (configured) or STOP.
REQ-017 STOP: sample 1 -> next clock rx_data <= shift register and po_flag=1; sample 0 -> next clock frame_err=1 and rx_data unchanged.
REQ-018 From STOP the FSM SHALL return to IDLE in the clock after the stop sample, so a start edge arriving half a bit later is accepted (back-to-back frames).
REQ-019 po_flag, frame_err and parity_err SHALL each be high exactly one clock per event and never simultaneously with frame_err and po_flag both high.
REQ-020 rx_data SHALL hold its value between po_flag pulses.
REQ-021 rx_busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-022 On srst low, asynchronously: state=IDLE, baud_cnt=0, bit_cnt=0, shift register=0, s1/s2/s3=1, rx_data=8'h00, po_flag=0, frame_err=0, parity_err=0, rx_busy=0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no output pulse; after release, reception SHALL resume on the next start edge.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: one even-parity bit SHALL follow data (PARITY state, same sample rule); mismatch -> parity_err pulses in the same cycle as po_flag, rx_data still updated.
REQ-025 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame = start+8 data+stop, parity_err tied to 0.

Verification (BAUD_CNT_MAX=28, bit period 29 clocks)
REQ-026 Frame 8'hA5 with good stop -> one po_flag pulse, rx_data=8'hA5, frame_err=0, rx_busy high for the frame.
REQ-027 Low glitch of 5 clocks on idle line -> START sample reads 1, returns to IDLE, no po_flag/frame_err.
REQ-028 Frame 8'h3C with stop bit driven 0 -> frame_err one pulse, no po_flag, rx_data keeps previous 8'hA5.
REQ-029 Back-to-back 8'h00 then 8'hFF, no idle gap -> two po_flag pulses, rx_data 8'h00 then 8'hFF.
REQ-030 srst low for 3 clocks during data bit 4 of 8'h55, then frame 8'h81 -> no pulse for the aborted frame, all outputs at reset values, then rx_data=8'h81.
REQ-031 With UART_RX_PARITY_EN: 8'h07 with parity bit 1 -> po_flag, no parity_err; with parity bit 0 -> po_flag and parity_err in same cycle.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 3-flop input synchronizer and mid-bit sampling.
// Ports: sclk (clock), srst (async active-low reset), rs232_rx (serial line, idle high),
//        rx_data (last good byte), po_flag (rx_data updated pulse),
//        frame_err (bad stop bit pulse), parity_err (parity mismatch pulse),
//        rx_busy (frame in progress).
// Option: define UART_RX_PARITY_EN to add one even-parity bit between data and stop.
module uart_rx #(
    parameter int BAUD_CNT_MAX = 5207
) (
    input  logic       sclk,
    input  logic       srst,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       po_flag,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam logic [12:0] CNT_MAX  = 13'(BAUD_CNT_MAX);
    localparam logic [12:0] CNT_HALF = 13'(BAUD_CNT_MAX / 2);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic        s1;
    logic        s2;
    logic        s3;
    logic [12:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        start_edge;
    logic        sample;
`ifdef UART_RX_PARITY_EN
    logic        par_bit;
`endif

    // s1 may go metastable; s2/s3 are clean, and s3 is the sampled line.
    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= rs232_rx;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign start_edge = !s2 && s3;

    // Guarded by state so a tiny BAUD_CNT_MAX (half == 0) cannot fire in IDLE.
    assign sample = (state != IDLE) && (baud_cnt == CNT_HALF);

    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
        end else begin
            state   <= state_nxt;
            rx_busy <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_edge)
                    state_nxt = START;
            end
            START: begin
                if (sample)
                    state_nxt = s3 ? IDLE : DATA;
            end
            DATA: begin
                if (sample && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample)
                    state_nxt = STOP;
            end
`endif
            STOP: begin
                // Leave right after the stop sample so a start edge half a
                // bit later is already seen in IDLE.
                if (sample)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            rx_data    <= 8'h00;
            po_flag    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            po_flag    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;

            // Held at zero in IDLE, so entering START always starts a fresh period.
            if (state == IDLE)
                baud_cnt <= '0;
            else if (baud_cnt == CNT_MAX)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 13'd1;

            if (state == START && sample)
                bit_cnt <= '0;

            if (state == DATA && sample) begin
                shreg   <= {s3, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end

`ifdef UART_RX_PARITY_EN
            if (state == PARITY && sample)
                par_bit <= s3;
`endif

            if (state == STOP && sample) begin
                if (s3) begin
                    rx_data <= shreg;
                    po_flag <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    // Even parity: parity bit must equal XOR of the data bits.
                    parity_err <= (par_bit != ^shreg);
`endif
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames against a frame-level model of uart_rx.
// Model predicts pulse cycles, rx_data and rx_busy windows from frame contents.
module tb_uart_rx;

    localparam int BIT  = 29;
    localparam int MAXC = 40000;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    // 2 sync flops + edge register, then half a bit (14) + 1 to register the stop sample.
    localparam int LAT = 3 + BIT * NB + 15;

    logic       sclk = 1'b0;
    logic       srst;
    logic       rs232_rx;
    logic [7:0] rx_data;
    logic       po_flag;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    bit         exp_po   [MAXC];
    bit         exp_fe   [MAXC];
    bit         exp_pe   [MAXC];
    bit         exp_busy [MAXC];
    logic [7:0] exp_byte [MAXC];

    int         po_cnt = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         last_po_cyc = 0;
    logic [7:0] got_q[$];
    logic [7:0] cur_data = 8'h00;

    uart_rx #(.BAUD_CNT_MAX(28)) dut (
        .sclk       (sclk),
        .srst       (srst),
        .rs232_rx   (rs232_rx),
        .rx_data    (rx_data),
        .po_flag    (po_flag),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_busy    (rx_busy)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Compare process: every cycle, DUT vs model.
    always @(negedge sclk) begin
        if (!srst) begin
            cur_data = 8'h00;
            chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
            chk("rst_po", {31'd0, po_flag}, 32'd0);
            chk("rst_fe", {31'd0, frame_err}, 32'd0);
            chk("rst_pe", {31'd0, parity_err}, 32'd0);
            chk("rst_busy", {31'd0, rx_busy}, 32'd0);
        end else if (cyc < MAXC) begin
            if (exp_po[cyc])
                cur_data = exp_byte[cyc];
            chk("po_flag", {31'd0, po_flag}, {31'd0, exp_po[cyc]});
            chk("frame_err", {31'd0, frame_err}, {31'd0, exp_fe[cyc]});
            chk("parity_err", {31'd0, parity_err}, {31'd0, exp_pe[cyc]});
            chk("rx_busy", {31'd0, rx_busy}, {31'd0, exp_busy[cyc]});
            chk("rx_data", {24'd0, rx_data}, {24'd0, cur_data});
        end
        if (po_flag) begin
            po_cnt++;
            last_po_cyc = cyc;
            got_q.push_back(rx_data);
        end
        if (frame_err)
            fe_cnt++;
        if (parity_err)
            pe_cnt++;
    end

    task automatic set_busy(input int from, input int upto);
        for (int c = from; c <= upto; c++)
            if (c < MAXC)
                exp_busy[c] = 1'b1;
    endtask

    // Frame-level prediction: line falls at cycle t0.
    task automatic model_frame(input int t0, input logic [7:0] d,
                               input bit p, input bit stop);
        int te;
        te = t0 + LAT;
        set_busy(t0 + 3, te - 1);
        if (te < MAXC) begin
            if (stop) begin
                exp_po[te]   = 1'b1;
                exp_byte[te] = d;
`ifdef UART_RX_PARITY_EN
                exp_pe[te]   = (p != ^d);
`endif
            end else begin
                exp_fe[te] = 1'b1;
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rs232_rx = 1'b1;
        wait_cyc(n);
    endtask

    task automatic drive_bit(input bit b);
        rs232_rx = b;
        wait_cyc(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop,
                              input bit par_ok, output int t0);
        bit p;
        t0 = cyc;
        p = (^d) ^ !par_ok;
        model_frame(t0, d, p, stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(p);
`endif
        drive_bit(stop);
        rs232_rx = 1'b1;
    endtask

    // Short low pulse: START samples high at mid-bit and gives up.
    task automatic glitch(input int g);
        int t0;
        t0 = cyc;
        set_busy(t0 + 3, t0 + 17);
        rs232_rx = 1'b0;
        wait_cyc(g);
        rs232_rx = 1'b1;
        wait_cyc(25 - g);
    endtask

    // 8'h55 interrupted by reset inside data bit 4.
    task automatic abort_frame();
        int t0;
        logic [7:0] d;
        d = 8'h55;
        t0 = cyc;
        set_busy(t0 + 3, t0 + 5 * BIT + 10 - 1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++)
            drive_bit(d[i]);
        rs232_rx = d[4];
        wait_cyc(10);
        srst = 1'b0;
        #1;
        chk("abort_rx_data", {24'd0, rx_data}, 32'd0);
        chk("abort_busy", {31'd0, rx_busy}, 32'd0);
        wait_cyc(3);
        srst = 1'b1;
        idle(40);
    endtask

    initial begin
        int t0;
        int p0;
        int f0;
        int e0;
        bit stop;
        srst = 1'b0;
        rs232_rx = 1'b1;
        wait_cyc(5);
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        chk("reset_busy", {31'd0, rx_busy}, 32'd0);
        srst = 1'b1;
        idle(10);

        p0 = po_cnt; f0 = fe_cnt;
        send_frame(8'hA5, 1'b1, 1'b1, t0);
        idle(20);
        chk("a5_po_count", po_cnt - p0, 1);
        chk("a5_fe_count", fe_cnt - f0, 0);
        chk("a5_rx_data", {24'd0, rx_data}, 32'hA5);
`ifdef UART_RX_PARITY_EN
        chk("a5_latency", last_po_cyc - t0, 308);
`else
        chk("a5_latency", last_po_cyc - t0, 279);
`endif

        p0 = po_cnt; f0 = fe_cnt;
        glitch(5);
        idle(10);
        chk("glitch_po_count", po_cnt - p0, 0);
        chk("glitch_fe_count", fe_cnt - f0, 0);

        p0 = po_cnt; f0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b1, t0);
        idle(20);
        chk("3c_fe_count", fe_cnt - f0, 1);
        chk("3c_po_count", po_cnt - p0, 0);
        chk("3c_rx_data", {24'd0, rx_data}, 32'hA5);

        p0 = po_cnt;
        send_frame(8'h00, 1'b1, 1'b1, t0);
        send_frame(8'hFF, 1'b1, 1'b1, t0);
        idle(20);
        chk("b2b_po_count", po_cnt - p0, 2);
        chk("b2b_first", {24'd0, got_q[got_q.size() - 2]}, 32'h00);
        chk("b2b_second", {24'd0, got_q[got_q.size() - 1]}, 32'hFF);

        p0 = po_cnt; f0 = fe_cnt;
        abort_frame();
        chk("abort_po_count", po_cnt - p0, 0);
        chk("abort_fe_count", fe_cnt - f0, 0);
        send_frame(8'h81, 1'b1, 1'b1, t0);
        idle(20);
        chk("81_po_count", po_cnt - p0, 1);
        chk("81_rx_data", {24'd0, rx_data}, 32'h81);

`ifdef UART_RX_PARITY_EN
        p0 = po_cnt; e0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1, t0);
        idle(20);
        chk("par_ok_po", po_cnt - p0, 1);
        chk("par_ok_pe", pe_cnt - e0, 0);
        p0 = po_cnt; e0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b0, t0);
        idle(20);
        chk("par_bad_po", po_cnt - p0, 1);
        chk("par_bad_pe", pe_cnt - e0, 1);
        chk("par_bad_data", {24'd0, rx_data}, 32'h07);
`else
        e0 = pe_cnt;
`endif

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                glitch(int'($urandom_range(1, 10)));
            end else begin
                stop = ($urandom_range(0, 5) != 0);
                send_frame(8'($urandom), stop, ($urandom_range(0, 3) != 0), t0);
                idle(int'($urandom_range(stop ? 0 : 1, 30)));
            end
        end
        idle(40);
`ifndef UART_RX_PARITY_EN
        chk("no_parity_pe", pe_cnt - e0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
